nrs_cinit_ctrl: RTL and testbench

Sequencer that computes the NB-IoT NRS scrambling seed
c_init = 2^10 * (7*(ns+1) + l + 1) * (2*N_ID + 1) + 2*N_ID + 1
using one shared 18-bit registered adder instance. The adder takes `a` and `b`; when `en` is high, `a+b` (truncated to 18 bits) is registered into `sum` on the next clk edge.
This block owns the adder's a, b and en inputs and reads back its registered sum. It sits between the slot/symbol scheduler (start, ns, l, N_ID) and the Gold-sequence generator (cinit_out, cinit_valid).

---
 rtl/nrs_cinit_ctrl.sv | 127 ++++++++++++
 tb/tb_nrs_cinit_ctrl.sv | 251 +++++++++++++++++++++++++
 2 files changed

// File: rtl/nrs_cinit_ctrl.sv
// NB-IoT NRS scrambling seed sequencer. Builds c_init with a single shared
// registered adder: three adds for A = 7(ns+1)+l+1, then an 8-step Horner multiply by 2N_ID+1.
module nrs_cinit_ctrl #(
    parameter int WIDTH   = 18,
    parameter int NS_W    = 5,
    parameter int L_W     = 3,
    parameter int NID_W   = 9,
    parameter int CINIT_W = WIDTH + 10
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic [NS_W-1:0]    ns,
    input  logic [L_W-1:0]     l,
    input  logic [NID_W-1:0]   nid,
    output logic [WIDTH-1:0]   add_a,
    output logic [WIDTH-1:0]   add_b,
    output logic               add_en,
    input  logic [WIDTH-1:0]   add_sum,
    output logic               busy,
    output logic [CINIT_W-1:0] cinit_out,
    output logic               cinit_valid
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] A0    = 3'd1;
    localparam logic [2:0] A1    = 3'd2;
    localparam logic [2:0] A2    = 3'd3;
    localparam logic [2:0] LATCH = 3'd4;
    localparam logic [2:0] MUL   = 3'd5;
    localparam logic [2:0] FIN   = 3'd6;

    logic [2:0]       state;
    logic [NS_W-1:0]  ns_r;
    logic [L_W-1:0]   l_r;
    logic [NID_W-1:0] nid_r;
    logic [7:0]       mreg;
    logic [2:0]       bit_i;

    logic [NS_W:0]    nsp1;
    logic [L_W:0]     lp1;
    logic [NID_W:0]   m_val;

    assign nsp1  = {1'b0, ns_r} + 1'b1;
    assign lp1   = {1'b0, l_r} + 1'b1;
    assign m_val = {nid_r, 1'b1};
    assign busy  = (state != IDLE);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            ns_r        <= '0;
            l_r         <= '0;
            nid_r       <= '0;
            mreg        <= '0;
            bit_i       <= '0;
            cinit_out   <= '0;
            cinit_valid <= 1'b0;
        end else begin
            cinit_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        ns_r  <= ns;
                        l_r   <= l;
                        nid_r <= nid;
                        state <= A0;
                    end
                end
                A0:    state <= A1;
                A1:    state <= A2;
                A2:    state <= LATCH;
                LATCH: begin
                    // A never exceeds 8 bits, so only its low byte drives the multiply
                    mreg  <= add_sum[7:0];
                    bit_i <= 3'd7;
                    state <= MUL;
                end
                MUL: begin
                    bit_i <= bit_i - 3'd1;
                    if (bit_i == 3'd0) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    cinit_out   <= CINIT_W'({add_sum, m_val});
                    cinit_valid <= 1'b1;
                    state       <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Adder operands; the first Horner step starts from zero instead of the stale sum
    always_comb begin
        add_en = 1'b0;
        add_a  = '0;
        add_b  = '0;
        case (state)
            A0: begin
                add_en = 1'b1;
                add_a  = WIDTH'({nsp1, 2'b00});
                add_b  = WIDTH'({nsp1, 1'b0});
            end
            A1: begin
                add_en = 1'b1;
                add_a  = add_sum;
                add_b  = WIDTH'(nsp1);
            end
            A2: begin
                add_en = 1'b1;
                add_a  = add_sum;
                add_b  = WIDTH'(lp1);
            end
            MUL: begin
                add_en = 1'b1;
                add_a  = (bit_i == 3'd7) ? '0 : {add_sum[WIDTH-2:0], 1'b0};
                add_b  = mreg[bit_i] ? WIDTH'(m_val) : '0;
            end
            default: begin
                add_en = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_nrs_cinit_ctrl.sv
// Bench for nrs_cinit_ctrl: provides the shared adder, a cycle-level reference
// model of the operand sequence, and a scoreboard of expected seeds.
module tb_nrs_cinit_ctrl;

    localparam int WIDTH   = 18;
    localparam int CINIT_W = 28;

    logic               clk = 1'b0;
    logic               rst = 1'b0;
    logic               start = 1'b0;
    logic [4:0]         ns = '0;
    logic [2:0]         l = '0;
    logic [8:0]         nid = '0;
    logic [WIDTH-1:0]   add_a;
    logic [WIDTH-1:0]   add_b;
    logic               add_en;
    logic [WIDTH-1:0]   add_sum;
    logic               busy;
    logic [CINIT_W-1:0] cinit_out;
    logic               cinit_valid;

    nrs_cinit_ctrl dut (
        .clk(clk), .rst(rst), .start(start), .ns(ns), .l(l), .nid(nid),
        .add_a(add_a), .add_b(add_b), .add_en(add_en), .add_sum(add_sum),
        .busy(busy), .cinit_out(cinit_out), .cinit_valid(cinit_valid)
    );

    always #5 clk = ~clk;

    // Shared registered adder
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) add_sum <= '0;
        else if (add_en) add_sum <= add_a + add_b;
    end

    // Reference model: phase 0 idle, 1..3 adds, 4 latch, 5..12 multiply, 13 finish
    int               p;
    logic [4:0]       m_ns;
    logic [2:0]       m_l;
    logic [8:0]       m_nid;
    logic [WIDTH-1:0] acc;
    logic             exp_valid;
    logic             accepted;
    logic             exp_en;
    logic [WIDTH-1:0] exp_a;
    logic [WIDTH-1:0] exp_b;
    int               m_a_val;
    int               m_m_val;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            p         <= 0;
            m_ns      <= '0;
            m_l       <= '0;
            m_nid     <= '0;
            acc       <= '0;
            exp_valid <= 1'b0;
            accepted  <= 1'b0;
        end else begin
            exp_valid <= (p == 13);
            accepted  <= 1'b0;
            if (p == 0) begin
                if (start) begin
                    m_ns     <= ns;
                    m_l      <= l;
                    m_nid    <= nid;
                    p        <= 1;
                    accepted <= 1'b1;
                end
            end else begin
                p <= (p == 13) ? 0 : p + 1;
            end
            if (exp_en) acc <= exp_a + exp_b;
        end
    end

    always_comb begin
        int bit_idx;
        m_a_val = 7 * (int'(m_ns) + 1) + int'(m_l) + 1;
        m_m_val = 2 * int'(m_nid) + 1;
        bit_idx = 12 - p;
        exp_en  = 1'b0;
        exp_a   = '0;
        exp_b   = '0;
        if (p == 1) begin
            exp_en = 1'b1;
            exp_a  = WIDTH'((int'(m_ns) + 1) * 4);
            exp_b  = WIDTH'((int'(m_ns) + 1) * 2);
        end else if (p == 2) begin
            exp_en = 1'b1;
            exp_a  = acc;
            exp_b  = WIDTH'(int'(m_ns) + 1);
        end else if (p == 3) begin
            exp_en = 1'b1;
            exp_a  = acc;
            exp_b  = WIDTH'(int'(m_l) + 1);
        end else if (p >= 5 && p <= 12) begin
            exp_en = 1'b1;
            exp_a  = (p == 5) ? '0 : WIDTH'(acc << 1);
            exp_b  = ((m_a_val >> bit_idx) & 1) != 0 ? WIDTH'(m_m_val) : '0;
        end
    end

    int total = 0;
    int bad   = 0;
    logic [CINIT_W-1:0] sb[$];

    typedef struct {
        logic [4:0]         ns;
        logic [2:0]         l;
        logic [8:0]         nid;
        logic [CINIT_W-1:0] cinit;
    } vec_t;

    vec_t vecs[5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [CINIT_W-1:0] seed(input logic [4:0] n, input logic [2:0] s, input logic [8:0] id);
        longint a;
        longint m;
        a = 7 * (longint'(n) + 1) + longint'(s) + 1;
        m = 2 * longint'(id) + 1;
        return CINIT_W'(a * m * 1024 + m);
    endfunction

    // One cycle: advance to the falling edge and compare everything against the model
    task automatic tick();
        logic [CINIT_W-1:0] want;
        @(negedge clk);
        if (!rst) begin
            sb.delete();
            return;
        end
        if (accepted) sb.push_back(seed(m_ns, m_l, m_nid));
        check("busy", 32'(busy), 32'(p != 0));
        check("add_en", 32'(add_en), 32'(exp_en));
        check("add_a", 32'(add_a), 32'(exp_a));
        check("add_b", 32'(add_b), 32'(exp_b));
        check("cinit_valid", 32'(cinit_valid), 32'(exp_valid));
        if (cinit_valid) begin
            if (sb.size() == 0) begin
                check("sb_empty", 32'(cinit_out), 32'hFFFF_FFFF);
            end else begin
                want = sb.pop_front();
                check("sb_cinit", 32'(cinit_out), 32'(want));
            end
        end
    endtask

    task automatic wait_valid(input string name, inout int cyc, inout int busy_cnt, inout int en_cnt);
        while (!cinit_valid && cyc < 40) begin
            tick();
            cyc++;
            if (busy) busy_cnt++;
            if (add_en) en_cnt++;
        end
        if (!cinit_valid) check({name, "_timeout"}, 32'd0, 32'd1);
    endtask

    task automatic apply_stimulus(input logic [4:0] n, input logic [2:0] s, input logic [8:0] id,
                                  input logic [CINIT_W-1:0] want, input string name);
        int cyc;
        int busy_cnt;
        int en_cnt;
        ns = n; l = s; nid = id; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 1;
        busy_cnt = busy ? 1 : 0;
        en_cnt = add_en ? 1 : 0;
        wait_valid(name, cyc, busy_cnt, en_cnt);
        check({name, "_cinit"}, 32'(cinit_out), 32'(want));
        // Valid is seen on the falling edge after the sampling edge plus 13 edges
        check({name, "_latency"}, 32'(cyc), 32'd14);
        check({name, "_busy_cycles"}, 32'(busy_cnt), 32'd13);
        check({name, "_en_cycles"}, 32'(en_cnt), 32'd11);
    endtask

    initial begin
        int cyc;
        int bc;
        int ec;
        vecs[0] = '{5'd0,  3'd5, 9'd0,   28'd13313};
        vecs[1] = '{5'd10, 3'd6, 9'd100, 28'd17289417};
        vecs[2] = '{5'd19, 3'd6, 9'd503, 28'd151582703};
        vecs[3] = '{5'd31, 3'd7, 9'd511, 28'd243033087};
        vecs[4] = '{5'd0,  3'd0, 9'd0,   28'd8193};

        rst = 1'b0;
        #1;
        check("rst_cinit", 32'(cinit_out), 32'd0);
        check("rst_valid", 32'(cinit_valid), 32'd0);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_add_en", 32'(add_en), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (2) tick();

        for (int i = 0; i < 5; i++) begin
            apply_stimulus(vecs[i].ns, vecs[i].l, vecs[i].nid, vecs[i].cinit, $sformatf("vec%0d", i));
            tick();
        end

        // Start re-pulsed while busy must be ignored
        ns = 5'd10; l = 3'd6; nid = 9'd100; start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        ns = 5'd31; l = 3'd7; nid = 9'd511; start = 1'b1;
        tick();
        start = 1'b0;
        cyc = 3; bc = 0; ec = 0;
        wait_valid("ignore", cyc, bc, ec);
        check("ignore_cinit", 32'(cinit_out), 32'd17289417);
        // New request issued in the cinit_valid cycle
        apply_stimulus(5'd0, 3'd5, 9'd0, 28'd13313, "b2b");

        // Reset in the middle of the multiply
        tick();
        ns = 5'd2; l = 3'd3; nid = 9'd7; start = 1'b1;
        tick();
        start = 1'b0;
        repeat (7) tick();
        check("mid_in_mul", 32'(p), 32'd8);
        rst = 1'b0;
        #1;
        check("mid_cinit", 32'(cinit_out), 32'd0);
        check("mid_valid", 32'(cinit_valid), 32'd0);
        check("mid_busy", 32'(busy), 32'd0);
        check("mid_add_en", 32'(add_en), 32'd0);
        check("mid_add_a", 32'(add_a), 32'd0);
        repeat (3) tick();
        rst = 1'b1;
        repeat (12) tick();
        check("post_rst_cinit", 32'(cinit_out), 32'd0);
        apply_stimulus(5'd1, 3'd5, 9'd1, 28'd61443, "after_rst");
        repeat (2) tick();
        check("sb_drained", 32'(sb.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
